// File: rtl/cam_wr_arb_pkg.sv
// rtl/cam_wr_arb_pkg.sv - shared types and default geometry for the dual camera write arbiter
package cam_wr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUSY = 2'd2
  } arb_state_t;

  localparam int          DEF_BURST_LEN   = 64;
  localparam int          DEF_FRAME_WORDS = 153600;
  localparam logic [23:0] DEF_CAM0_BASE   = 24'h000000;
  localparam logic [23:0] DEF_CAM1_BASE   = 24'h100000;

endpackage

// File: rtl/cam_wr_ptr.sv
// rtl/cam_wr_ptr.sv - per-camera frame write pointer: offset, arming, pending frame reset, eligibility
// Optional WR_PINGPONG_EN: alternate between two frame buffers and report the last completed bank.
module cam_wr_ptr
  import cam_wr_arb_pkg::*;
#(
  parameter int BURST_LEN   = DEF_BURST_LEN,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int ADDR_W      = 24,
  parameter int FIFO_CNT_W  = 10,
  localparam int LEN_W      = $clog2(BURST_LEN) + 1,
  localparam int OFS_W      = $clog2(FRAME_WORDS + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_frame_rst,
  input  logic [FIFO_CNT_W-1:0] i_fifo_cnt,
  input  logic                  i_granted,
  input  logic                  i_commit,
  input  logic [LEN_W-1:0]      i_commit_len,
  output logic [LEN_W-1:0]      o_need,
  output logic                  o_elig,
  output logic [ADDR_W-1:0]     o_addr_ofs,
  output logic                  o_frame_done
`ifdef WR_PINGPONG_EN
  ,
  output logic                  o_rd_bank
`endif
);

  localparam int CMP_W = (FIFO_CNT_W > LEN_W) ? FIFO_CNT_W : LEN_W;
  localparam logic [OFS_W-1:0] FRAME_OFS = OFS_W'(FRAME_WORDS);
  localparam logic [OFS_W-1:0] BURST_OFS = OFS_W'(BURST_LEN);

  logic [OFS_W-1:0] ofs;
  logic [OFS_W-1:0] remain;
  logic [OFS_W-1:0] ofs_next;
  logic             armed;
  logic             pend;

  assign remain   = FRAME_OFS - ofs;
  assign ofs_next = ofs + OFS_W'(i_commit_len);
  assign o_need   = (remain >= BURST_OFS) ? LEN_W'(BURST_LEN) : LEN_W'(remain);
  assign o_elig   = armed && (remain != '0) && !i_frame_rst &&
                    (CMP_W'(i_fifo_cnt) >= CMP_W'(o_need));

`ifdef WR_PINGPONG_EN
  logic bank;

  assign o_addr_ofs = ADDR_W'(ofs) + (bank ? ADDR_W'(FRAME_WORDS) : '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bank      <= 1'b0;
      o_rd_bank <= 1'b0;
    end else if (i_commit && !pend && !i_frame_rst && (ofs_next == FRAME_OFS)) begin
      o_rd_bank <= bank;
      bank      <= ~bank;
    end
  end
`else
  assign o_addr_ofs = ADDR_W'(ofs);
`endif

  // A frame reset that lands while our burst is in flight is deferred to the burst's completion.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ofs          <= '0;
      armed        <= 1'b1;
      pend         <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      if (i_commit) begin
        if (pend || i_frame_rst) begin
          ofs   <= '0;
          armed <= 1'b1;
          pend  <= 1'b0;
        end else begin
          ofs <= ofs_next;
          if (ofs_next == FRAME_OFS) begin
            armed        <= 1'b0;
            o_frame_done <= 1'b1;
          end
        end
      end else if (i_frame_rst) begin
        if (i_granted) begin
          pend <= 1'b1;
        end else begin
          ofs   <= '0;
          armed <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dual_cam_wr_arbiter.sv
// rtl/dual_cam_wr_arbiter.sv - round-robin SDRAM write-burst arbiter for two camera FIFOs
// Optional WR_PINGPONG_EN: double-buffered frames, adds o_cam0_rd_bank / o_cam1_rd_bank.
module dual_cam_wr_arbiter
  import cam_wr_arb_pkg::*;
#(
  parameter int              BURST_LEN   = DEF_BURST_LEN,
  parameter int              ADDR_W      = 24,
  parameter int              FRAME_WORDS = DEF_FRAME_WORDS,
  parameter logic [ADDR_W-1:0] CAM0_BASE = ADDR_W'(DEF_CAM0_BASE),
  parameter logic [ADDR_W-1:0] CAM1_BASE = ADDR_W'(DEF_CAM1_BASE),
  parameter int              FIFO_CNT_W  = 10,
  localparam int             LEN_W       = $clog2(BURST_LEN) + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cam0_frame_rst,
  input  logic [FIFO_CNT_W-1:0] i_cam0_fifo_cnt,
  input  logic                  i_cam1_frame_rst,
  input  logic [FIFO_CNT_W-1:0] i_cam1_fifo_cnt,
  output logic                  o_wr_req,
  output logic [ADDR_W-1:0]     o_wr_addr,
  output logic [LEN_W-1:0]      o_wr_len,
  output logic                  o_wr_sel,
  input  logic                  i_wr_ack,
  input  logic                  i_wr_done,
  output logic                  o_cam0_frame_done,
  output logic                  o_cam1_frame_done
`ifdef WR_PINGPONG_EN
  ,
  output logic                  o_cam0_rd_bank,
  output logic                  o_cam1_rd_bank
`endif
);

  arb_state_t          state;
  arb_state_t          state_nxt;
  logic                last_grant;
  logic                load;
  logic                grant_sel;
  logic                commit;
  logic [LEN_W-1:0]    need0;
  logic [LEN_W-1:0]    need1;
  logic                elig0;
  logic                elig1;
  logic [ADDR_W-1:0]   addr_ofs0;
  logic [ADDR_W-1:0]   addr_ofs1;
  logic                busy;

  assign busy = (state != IDLE);

  cam_wr_ptr #(
    .BURST_LEN   (BURST_LEN),
    .FRAME_WORDS (FRAME_WORDS),
    .ADDR_W      (ADDR_W),
    .FIFO_CNT_W  (FIFO_CNT_W)
  ) u_ptr0 (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_frame_rst  (i_cam0_frame_rst),
    .i_fifo_cnt   (i_cam0_fifo_cnt),
    .i_granted    (busy && !o_wr_sel),
    .i_commit     (commit && !o_wr_sel),
    .i_commit_len (o_wr_len),
    .o_need       (need0),
    .o_elig       (elig0),
    .o_addr_ofs   (addr_ofs0),
    .o_frame_done (o_cam0_frame_done)
`ifdef WR_PINGPONG_EN
    ,
    .o_rd_bank    (o_cam0_rd_bank)
`endif
  );

  cam_wr_ptr #(
    .BURST_LEN   (BURST_LEN),
    .FRAME_WORDS (FRAME_WORDS),
    .ADDR_W      (ADDR_W),
    .FIFO_CNT_W  (FIFO_CNT_W)
  ) u_ptr1 (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_frame_rst  (i_cam1_frame_rst),
    .i_fifo_cnt   (i_cam1_fifo_cnt),
    .i_granted    (busy && o_wr_sel),
    .i_commit     (commit && o_wr_sel),
    .i_commit_len (o_wr_len),
    .o_need       (need1),
    .o_elig       (elig1),
    .o_addr_ofs   (addr_ofs1),
    .o_frame_done (o_cam1_frame_done)
`ifdef WR_PINGPONG_EN
    ,
    .o_rd_bank    (o_cam1_rd_bank)
`endif
  );

  // Ack and done in the same REQ cycle complete the burst without visiting BUSY.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    grant_sel = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (elig0 || elig1) begin
          load      = 1'b1;
          grant_sel = (elig0 && elig1) ? ~last_grant : elig1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (i_wr_ack) begin
          commit    = i_wr_done;
          state_nxt = i_wr_done ? IDLE : BUSY;
        end
      end
      BUSY: begin
        if (i_wr_done) begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      o_wr_req   <= 1'b0;
      o_wr_addr  <= '0;
      o_wr_len   <= '0;
      o_wr_sel   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        o_wr_req  <= 1'b1;
        o_wr_sel  <= grant_sel;
        o_wr_addr <= grant_sel ? (CAM1_BASE + addr_ofs1) : (CAM0_BASE + addr_ofs0);
        o_wr_len  <= grant_sel ? need1 : need0;
      end else if ((state == REQ) && i_wr_ack) begin
        o_wr_req <= 1'b0;
      end
      if (commit) begin
        last_grant <= o_wr_sel;
      end
    end
  end

endmodule

// File: tb/tb_dual_cam_wr_arbiter.sv
// tb/tb_dual_cam_wr_arbiter.sv - self-checking bench for dual_cam_wr_arbiter (optionally WR_PINGPONG_EN)
module tb_dual_cam_wr_arbiter;

  localparam int BL = 64;
  localparam int FW = 200;
  localparam int AW = 24;
  localparam int CW = 10;
  localparam int LW = 7;
  localparam int B0 = 'h000000;
  localparam int B1 = 'h100000;
`ifdef WR_PINGPONG_EN
  localparam int PP = 1;
`else
  localparam int PP = 0;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_cam0_frame_rst = 1'b0;
  logic [CW-1:0] i_cam0_fifo_cnt = '0;
  logic          i_cam1_frame_rst = 1'b0;
  logic [CW-1:0] i_cam1_fifo_cnt = '0;
  logic          o_wr_req;
  logic [AW-1:0] o_wr_addr;
  logic [LW-1:0] o_wr_len;
  logic          o_wr_sel;
  logic          i_wr_ack = 1'b0;
  logic          i_wr_done = 1'b0;
  logic          o_cam0_frame_done;
  logic          o_cam1_frame_done;
`ifdef WR_PINGPONG_EN
  logic          o_cam0_rd_bank;
  logic          o_cam1_rd_bank;
`endif

  dual_cam_wr_arbiter #(
    .BURST_LEN   (BL),
    .ADDR_W      (AW),
    .FRAME_WORDS (FW),
    .CAM0_BASE   (24'h000000),
    .CAM1_BASE   (24'h100000),
    .FIFO_CNT_W  (CW)
  ) dut (
    .i_clk             (i_clk),
    .i_rst_n           (i_rst_n),
    .i_cam0_frame_rst  (i_cam0_frame_rst),
    .i_cam0_fifo_cnt   (i_cam0_fifo_cnt),
    .i_cam1_frame_rst  (i_cam1_frame_rst),
    .i_cam1_fifo_cnt   (i_cam1_fifo_cnt),
    .o_wr_req          (o_wr_req),
    .o_wr_addr         (o_wr_addr),
    .o_wr_len          (o_wr_len),
    .o_wr_sel          (o_wr_sel),
    .i_wr_ack          (i_wr_ack),
    .i_wr_done         (i_wr_done),
    .o_cam0_frame_done (o_cam0_frame_done),
    .o_cam1_frame_done (o_cam1_frame_done)
`ifdef WR_PINGPONG_EN
    ,
    .o_cam0_rd_bank    (o_cam0_rd_bank),
    .o_cam1_rd_bank    (o_cam1_rd_bank)
`endif
  );

  initial forever #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Controller responder: ack ack_dly cycles into a request, done done_dly cycles after ack.
  int ack_dly = 2;
  int done_dly = 10;
  bit ack_with_done = 0;

  initial begin
    int  cnt;
    bit  acked;
    cnt = 0;
    acked = 0;
    forever begin
      @(posedge i_clk);
      #1;
      i_wr_ack = 1'b0;
      i_wr_done = 1'b0;
      if (!i_rst_n) begin
        cnt = 0;
        acked = 0;
      end else if (!acked) begin
        if (o_wr_req) begin
          if (cnt >= ack_dly) begin
            i_wr_ack = 1'b1;
            cnt = 0;
            if (ack_with_done) i_wr_done = 1'b1;
            else acked = 1;
          end else begin
            cnt++;
          end
        end
      end else begin
        if (cnt >= done_dly) begin
          i_wr_done = 1'b1;
          acked = 0;
          cnt = 0;
        end else begin
          cnt++;
        end
      end
    end
  end

  // Behavioural model: burst bookkeeping per camera, evaluated once per cycle.
  bit m_req, m_fly, m_last, prev_req;
  int m_sel, m_addr, m_len;
  int m_ofs[2];
  bit m_armed[2], m_pend[2], m_done[2];
  int m_bank[2], m_rd[2];
  int g_sel[$], g_addr[$], g_len[$];
  int done_cnt[2];

  task automatic model_reset();
    m_req = 0; m_fly = 0; m_last = 1; prev_req = 0;
    m_sel = 0; m_addr = 0; m_len = 0;
    for (int c = 0; c < 2; c++) begin
      m_ofs[c] = 0; m_armed[c] = 1; m_pend[c] = 0; m_done[c] = 0;
      m_bank[c] = 0; m_rd[c] = 0;
    end
  endtask

  task automatic model_step();
    int rem[2], need[2], cnt[2];
    bit elig[2], gr[2], frst[2];
    bit com;
    int k;
    frst[0] = i_cam0_frame_rst;
    frst[1] = i_cam1_frame_rst;
    cnt[0] = int'(i_cam0_fifo_cnt);
    cnt[1] = int'(i_cam1_fifo_cnt);
    for (int c = 0; c < 2; c++) begin
      rem[c]  = FW - m_ofs[c];
      need[c] = (rem[c] < BL) ? rem[c] : BL;
      elig[c] = m_armed[c] && (rem[c] != 0) && (cnt[c] >= need[c]) && !frst[c];
      gr[c]   = (m_req || m_fly) && (m_sel == c);
      m_done[c] = 0;
    end
    com = 0;
    if (!m_req && !m_fly) begin
      if (elig[0] || elig[1]) begin
        k = (elig[0] && elig[1]) ? (m_last ? 0 : 1) : (elig[1] ? 1 : 0);
        m_req  = 1;
        m_sel  = k;
        m_len  = need[k];
        m_addr = ((k ? B1 : B0) + PP * m_bank[k] * FW + m_ofs[k]) % (1 << AW);
      end
    end else if (m_req) begin
      if (i_wr_ack) begin
        m_req = 0;
        if (i_wr_done) com = 1;
        else m_fly = 1;
      end
    end else if (i_wr_done) begin
      m_fly = 0;
      com = 1;
    end
    if (com) begin
      k = m_sel;
      m_last = k[0];
      if (m_pend[k] || frst[k]) begin
        m_ofs[k] = 0; m_armed[k] = 1; m_pend[k] = 0;
      end else begin
        m_ofs[k] += m_len;
        if (m_ofs[k] == FW) begin
          m_done[k] = 1; m_armed[k] = 0;
          m_rd[k] = m_bank[k]; m_bank[k] = 1 - m_bank[k];
        end
      end
    end
    for (int c = 0; c < 2; c++) begin
      if (frst[c] && !(com && m_sel == c)) begin
        if (gr[c]) m_pend[c] = 1;
        else begin m_ofs[c] = 0; m_armed[c] = 1; end
      end
    end
  endtask

  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      model_reset();
    end else begin
      check("wr_req", o_wr_req, m_req);
      if (m_req) begin
        check("wr_sel", o_wr_sel, m_sel);
        check("wr_addr", o_wr_addr, m_addr);
        check("wr_len", o_wr_len, m_len);
      end
      check("cam0_frame_done", o_cam0_frame_done, m_done[0]);
      check("cam1_frame_done", o_cam1_frame_done, m_done[1]);
`ifdef WR_PINGPONG_EN
      check("cam0_rd_bank", o_cam0_rd_bank, m_rd[0]);
      check("cam1_rd_bank", o_cam1_rd_bank, m_rd[1]);
`endif
      if (o_wr_req && !prev_req) begin
        g_sel.push_back(int'(o_wr_sel));
        g_addr.push_back(int'(o_wr_addr));
        g_len.push_back(int'(o_wr_len));
      end
      prev_req = o_wr_req;
      if (o_cam0_frame_done) done_cnt[0]++;
      if (o_cam1_frame_done) done_cnt[1]++;
      model_step();
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic clear_log();
    g_sel.delete(); g_addr.delete(); g_len.delete();
    done_cnt[0] = 0; done_cnt[1] = 0;
  endtask

  task automatic restart(input int f0, input int f1);
    i_rst_n = 1'b0;
    i_cam0_frame_rst = 1'b0;
    i_cam1_frame_rst = 1'b0;
    i_cam0_fifo_cnt = CW'(f0);
    i_cam1_fifo_cnt = CW'(f1);
    step(2);
    clear_log();
    i_rst_n = 1'b1;
  endtask

  task automatic wait_grants(input int n, input string nm);
    int t;
    t = 0;
    while (g_addr.size() < n && t < 400) begin
      step(1);
      t++;
    end
    check({nm, "_grant_timeout"}, (g_addr.size() >= n), 1);
  endtask

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    while ((m_req || m_fly || o_wr_req) && t < 400) begin
      step(1);
      t++;
    end
    check({nm, "_idle_timeout"}, (t < 400), 1);
  endtask

  initial begin
    int t;
    // reset state and round robin between two ready cameras
    step(2);
    check("rst_wr_req", o_wr_req, 0);
    check("rst_wr_addr", o_wr_addr, 0);
    check("rst_wr_len", o_wr_len, 0);
    check("rst_wr_sel", o_wr_sel, 0);
    check("rst_cam0_done", o_cam0_frame_done, 0);
    check("rst_cam1_done", o_cam1_frame_done, 0);
    restart(64, 64);
    wait_grants(3, "rr");
    check("rr_g0_sel", g_sel[0], 0);
    check("rr_g0_addr", g_addr[0], 0);
    check("rr_g0_len", g_len[0], 64);
    check("rr_g1_sel", g_sel[1], 1);
    check("rr_g1_addr", g_addr[1], 'h100000);
    check("rr_g1_len", g_len[1], 64);
    check("rr_g2_sel", g_sel[2], 0);
    check("rr_g2_addr", g_addr[2], 64);
    // asynchronous reset in the middle of a burst
    step(3);
    i_rst_n = 1'b0;
    #1;
    check("async_rst_req", o_wr_req, 0);
    check("async_rst_addr", o_wr_addr, 0);
    check("async_rst_len", o_wr_len, 0);

    // cam0 alone through a complete frame, short last burst
    restart(64, 0);
    wait_grants(3, "frame");
    i_cam0_fifo_cnt = CW'(8);
    wait_grants(4, "frame_tail");
    check("tail_addr", g_addr[3], 192);
    check("tail_len", g_len[3], 8);
    wait_idle("frame");
    i_cam0_fifo_cnt = CW'(64);
    step(30);
    check("frame_done_once", done_cnt[0], 1);
    check("no_req_after_frame", g_addr.size(), 4);
    i_cam0_frame_rst = 1'b1;
    step(1);
    i_cam0_frame_rst = 1'b0;
    wait_grants(5, "new_frame");
    check("new_frame_addr", g_addr[4], 0);

    // fifo threshold and request held while ack is withheld
    ack_dly = 20;
    restart(63, 0);
    step(10);
    check("below_need_no_req", g_addr.size(), 0);
    i_cam0_fifo_cnt = CW'(64);
    t = 0;
    while (!o_wr_req && t < 2) begin
      step(1);
      t++;
    end
    check("req_within_2", o_wr_req, 1);
    step(15);
    check("hold_req", o_wr_req, 1);
    check("hold_addr", o_wr_addr, 0);
    check("hold_len", o_wr_len, 64);
    check("hold_sel", o_wr_sel, 0);
    wait_idle("hold");
    ack_dly = 2;

    // frame reset while cam0 is busy at offset 64
    restart(64, 0);
    wait_grants(2, "pend");
    t = 0;
    while (o_wr_req && t < 40) begin
      step(1);
      t++;
    end
    check("pend_in_busy", o_wr_req, 0);
    i_cam0_frame_rst = 1'b1;
    step(1);
    i_cam0_frame_rst = 1'b0;
    wait_grants(3, "pend_after");
    check("pend_prev_addr", g_addr[1], 64);
    check("pend_next_addr", g_addr[2], 0);
    check("pend_no_done", done_cnt[0], 0);

    // ack and done together; cam1 frame(s)
    ack_with_done = 1;
    restart(0, 64);
    wait_grants(4, "fast");
    check("fast_g1_addr", g_addr[1], 'h100040);
    check("fast_g3_addr", g_addr[3], 'h1000C0);
    check("fast_g3_len", g_len[3], 8);
    wait_idle("fast");
    step(2);
    check("cam1_done_once", done_cnt[1], 1);
`ifdef WR_PINGPONG_EN
    check("rd_bank_first", o_cam1_rd_bank, 0);
`endif
    i_cam1_frame_rst = 1'b1;
    step(1);
    i_cam1_frame_rst = 1'b0;
    wait_grants(5, "frame2");
    check("frame2_addr", g_addr[4], PP ? 'h1000C8 : 'h100000);
`ifdef WR_PINGPONG_EN
    wait_grants(8, "frame2_end");
    wait_idle("frame2");
    step(2);
    check("cam1_done_twice", done_cnt[1], 2);
    check("rd_bank_second", o_cam1_rd_bank, 1);
`endif
    wait_idle("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
